// File: rtl/io_port.sv
// io_port: memory-mapped I/O unit sitting downstream of the CPU core.
// It decodes CPU I/O cycles into a small register window that holds a
// first-word-fall-through TX FIFO, a synchronised input port and an
// optional compare timer.
// The timer is built only when IO_PORT_TIMER_EN is defined. Without it,
// registers 3..5 read zero and ignore writes, and STATUS.texp reads zero.
// Register reads are combinational so the single-cycle core sees its data
// in the same cycle. Writes take effect on the clock edge.
module io_port #(
  parameter int FIFO_DEPTH = 4,
  parameter int GPIN_W     = 16,
  parameter int TIMER_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       a_in,
  input  logic [15:0]       d_in,
  input  logic              wen_in,
  input  logic              iom_in,
  output logic [15:0]       io_out,
  input  logic [GPIN_W-1:0] gpio_in,
  output logic [15:0]       tx_data_out,
  output logic              tx_valid_out,
  input  logic              tx_ready_in
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [2:0] REG_TXDATA = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_GPIN   = 3'd2;
  localparam logic [2:0] REG_TCMP   = 3'd3;
  localparam logic [2:0] REG_TCNT   = 3'd4;
  localparam logic [2:0] REG_TCTRL  = 3'd5;

  // Decode and handshake signals
  logic             sel;
  logic [2:0]       reg_idx;
  logic             wr_stb;
  logic             push;
  logic             status_wr;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop;
  logic             push_ok;
  logic             push_drop;

  // FIFO state
  logic [15:0]      mem_reg [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             ovf_reg;

  // Input synchroniser
  logic [GPIN_W-1:0] sync1_reg;
  logic [GPIN_W-1:0] sync2_reg;

  logic              texp_bit;
  logic [15:0]       status_word;

  // Address decode, write strobes and FIFO push/pop qualification
  always_comb begin
    sel        = iom_in && (a_in[15:3] == 13'd0);
    reg_idx    = a_in[2:0];
    wr_stb     = sel && wen_in;
    push       = wr_stb && (reg_idx == REG_TXDATA);
    status_wr  = wr_stb && (reg_idx == REG_STATUS);
    fifo_empty = (count_reg == '0);
    fifo_full  = (count_reg == DEPTH_C);
    pop        = !fifo_empty && tx_ready_in;
    // A push into a full FIFO still lands if the head leaves in the same cycle.
    push_ok    = push && (!fifo_full || pop);
    push_drop  = push && fifo_full && !pop;
  end

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        mem_reg[wr_ptr_reg] <= d_in;
        wr_ptr_reg          <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Sticky overflow flag, cleared by writing 1 to STATUS bit 3
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (push_drop) begin
      ovf_reg <= 1'b1;
    end else if (status_wr && d_in[3]) begin
      ovf_reg <= 1'b0;
    end
  end

  // Two-flop synchroniser for the asynchronous input port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= gpio_in;
      sync2_reg <= sync1_reg;
    end
  end

  // Sink side of the FIFO: head word shown only while non-empty
  always_comb begin
    tx_valid_out = !fifo_empty;
    tx_data_out  = fifo_empty ? 16'h0000 : mem_reg[rd_ptr_reg];
  end

`ifdef IO_PORT_TIMER_EN
  logic [TIMER_W-1:0] tcnt_reg;
  logic [TIMER_W-1:0] tcnt_next;
  logic [TIMER_W-1:0] tcmp_reg;
  logic [TIMER_W-1:0] tcmp_next;
  logic               en_reg;
  logic               en_next;
  logic               ar_reg;
  logic               ar_next;
  logic               texp_reg;
  logic               texp_next;
  logic               match;

  // Timer next state: count/match first, then CPU writes override
  always_comb begin
    tcnt_next = tcnt_reg;
    tcmp_next = tcmp_reg;
    en_next   = en_reg;
    ar_next   = ar_reg;
    texp_next = texp_reg;
    match     = en_reg && (tcnt_reg == tcmp_reg);

    if (status_wr && d_in[2]) begin
      texp_next = 1'b0;
    end
    // A match raises texp even when software is clearing it this cycle.
    if (match) begin
      texp_next = 1'b1;
      if (ar_reg) begin
        tcnt_next = '0;
      end else begin
        en_next = 1'b0;
      end
    end else if (en_reg) begin
      tcnt_next = tcnt_reg + TIMER_W'(1);
    end

    if (wr_stb && (reg_idx == REG_TCMP)) begin
      tcmp_next = d_in[TIMER_W-1:0];
    end
    if (wr_stb && (reg_idx == REG_TCNT)) begin
      tcnt_next = d_in[TIMER_W-1:0];
    end
    if (wr_stb && (reg_idx == REG_TCTRL)) begin
      en_next = d_in[0];
      ar_next = d_in[1];
    end
  end

  // Timer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_reg <= '0;
      tcmp_reg <= '1;
      en_reg   <= 1'b0;
      ar_reg   <= 1'b0;
      texp_reg <= 1'b0;
    end else begin
      tcnt_reg <= tcnt_next;
      tcmp_reg <= tcmp_next;
      en_reg   <= en_next;
      ar_reg   <= ar_next;
      texp_reg <= texp_next;
    end
  end

  assign texp_bit = texp_reg;
`else
  assign texp_bit = 1'b0;
`endif

  // STATUS layout: {8'0, count[3:0], ovf, texp, full, empty}
  always_comb begin
    status_word = {8'h00, 4'(count_reg), ovf_reg, texp_bit, fifo_full, fifo_empty};
  end

  // Combinational read mux; unselected or unmapped accesses return 0
  always_comb begin
    io_out = 16'h0000;
    if (sel) begin
      case (reg_idx)
        REG_STATUS: io_out = status_word;
        REG_GPIN:   io_out = 16'(sync2_reg);
`ifdef IO_PORT_TIMER_EN
        REG_TCMP:   io_out = 16'(tcmp_reg);
        REG_TCNT:   io_out = 16'(tcnt_reg);
        REG_TCTRL:  io_out = {14'd0, ar_reg, en_reg};
`endif
        default:    io_out = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_io_port.sv
// tb_io_port: scoreboard bench for io_port. Each stimulus cycle computes the
// expected combinational outputs from a queue/array model of the register
// window and pushes them; a monitor pops and compares on the falling edge.
module tb_io_port;

  localparam int DEPTH = 4;
  localparam int GW    = 16;
  localparam int TW    = 16;

  logic          clk = 1'b0;
  logic          run = 1'b0;
  logic          rst_n = 1'b1;
  logic [15:0]   a_in = '0;
  logic [15:0]   d_in = '0;
  logic          wen_in = 1'b0;
  logic          iom_in = 1'b0;
  logic [15:0]   io_out;
  logic [GW-1:0] gpio_in = '0;
  logic [15:0]   tx_data_out;
  logic          tx_valid_out;
  logic          tx_ready_in = 1'b0;

  io_port #(.FIFO_DEPTH(DEPTH), .GPIN_W(GW), .TIMER_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .d_in(d_in), .wen_in(wen_in),
    .iom_in(iom_in), .io_out(io_out), .gpio_in(gpio_in),
    .tx_data_out(tx_data_out), .tx_valid_out(tx_valid_out),
    .tx_ready_in(tx_ready_in)
  );

  always #5 if (run) clk = ~clk;

  typedef struct {
    logic [15:0] io;
    logic        v;
    logic [15:0] d;
    int          ph;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   phase = 0;
  int   cyc_no = 0;
  bit   in_reset = 1'b0;

  // Reference model state
  logic [15:0]   mq[$];
  bit            m_ovf;
  logic [GW-1:0] m_g1, m_g2;
  logic [TW-1:0] m_tcnt, m_tcmp;
  bit            m_en, m_ar, m_texp;
  logic [GW-1:0] g_cur = '0;

  function automatic void model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_g1   = '0;
    m_g2   = '0;
    m_tcnt = '0;
    m_tcmp = '1;
    m_en   = 1'b0;
    m_ar   = 1'b0;
    m_texp = 1'b0;
  endfunction

  function automatic logic [15:0] model_read(input logic [15:0] a, input logic iom);
    logic [15:0] e;
    e = 16'h0000;
    if (iom && a[15:3] == 13'd0) begin
      case (a[2:0])
        3'd1: e = {8'h00, 4'(mq.size()), m_ovf, m_texp,
                   (mq.size() == DEPTH), (mq.size() == 0)};
        3'd2: e = 16'(m_g2);
`ifdef IO_PORT_TIMER_EN
        3'd3: e = 16'(m_tcmp);
        3'd4: e = 16'(m_tcnt);
        3'd5: e = {14'd0, m_ar, m_en};
`endif
        default: e = 16'h0000;
      endcase
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // One clock cycle of stimulus, entered and left at posedge+1
  task automatic cycle(input logic [15:0] ta, input logic [15:0] td, input logic tw,
                       input logic tiom, input logic trdy, input logic [GW-1:0] tg);
    exp_t e;
    bit   sel, wr, pp;
    int   n;
    a_in = ta; d_in = td; wen_in = tw; iom_in = tiom; tx_ready_in = trdy; gpio_in = tg;
    #1;
    e.io  = model_read(ta, tiom);
    e.v   = (mq.size() > 0);
    e.d   = (mq.size() > 0) ? mq[0] : 16'h0000;
    e.ph  = phase;
    e.cyc = cyc_no;
    exp_q.push_back(e);
    cyc_no++;
    if (!in_reset) begin
      sel = tiom && (ta[15:3] == 13'd0);
      wr  = sel && tw;
      n   = mq.size();
      pp  = (n > 0) && trdy;
      if (pp) void'(mq.pop_front());
      if (wr && ta[2:0] == 3'd0) begin
        if (n < DEPTH || pp) mq.push_back(td);
        else m_ovf = 1'b1;
      end
      if (wr && ta[2:0] == 3'd1 && td[3]) m_ovf = 1'b0;
`ifdef IO_PORT_TIMER_EN
      begin
        logic [TW-1:0] n_tcnt, n_tcmp;
        bit n_en, n_ar, n_texp, hit;
        hit = m_en && (m_tcnt == m_tcmp);
        n_tcnt = m_tcnt; n_tcmp = m_tcmp; n_en = m_en; n_ar = m_ar; n_texp = m_texp;
        if (wr && ta[2:0] == 3'd1 && td[2]) n_texp = 1'b0;
        if (hit) begin
          n_texp = 1'b1;
          if (m_ar) n_tcnt = '0;
          else n_en = 1'b0;
        end else if (m_en) begin
          n_tcnt = m_tcnt + 1;
        end
        if (wr && ta[2:0] == 3'd3) n_tcmp = td[TW-1:0];
        if (wr && ta[2:0] == 3'd4) n_tcnt = td[TW-1:0];
        if (wr && ta[2:0] == 3'd5) begin
          n_en = td[0];
          n_ar = td[1];
        end
        m_tcnt = n_tcnt; m_tcmp = n_tcmp; m_en = n_en; m_ar = n_ar; m_texp = n_texp;
      end
`endif
      m_g2 = m_g1;
      m_g1 = tg;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic rdy);
    cycle(a, d, 1'b1, 1'b1, rdy, g_cur);
  endtask

  task automatic rd(input logic [15:0] a, input logic rdy);
    cycle(a, 16'h0000, 1'b0, 1'b1, rdy, g_cur);
  endtask

  // Direct look at a register against a constant taken from the register map
  task automatic peek(input string name, input logic [15:0] a, input logic [15:0] req);
    a_in = a; wen_in = 1'b0; iom_in = 1'b1; tx_ready_in = 1'b0;
    #1;
    chk(name, io_out, req);
  endtask

  // Asynchronous reset mid-operation, entered at posedge+1
  task automatic async_reset();
    a_in = 16'h0001; iom_in = 1'b1; wen_in = 1'b0;
    #2;
    rst_n = 1'b0;
    in_reset = 1'b1;
    model_reset();
    #1;
    chk("rst_valid", {15'd0, tx_valid_out}, 16'h0000);
    chk("rst_status", io_out, 16'h0001);
    @(posedge clk);
    #1;
    cycle(16'h0000, 16'h1234, 1'b1, 1'b1, 1'b1, g_cur);
    cycle(16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0, g_cur);
    rst_n = 1'b1;
    in_reset = 1'b0;
  endtask

  // Monitor: compares every presented output cycle against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (io_out !== e.io || tx_valid_out !== e.v || tx_data_out !== e.d) begin
          miscompares++;
          $display("FAIL scoreboard ph%0d cyc%0d: io=%h valid=%b data=%h, expected io=%h valid=%b data=%h",
                   e.ph, e.cyc, io_out, tx_valid_out, tx_data_out, e.io, e.v, e.d);
        end
      end
    end
  end

  initial begin
    logic [15:0] ra, rdat;
    int          rr, pready;

    // Reset with the clock idle
    phase = 0;
    model_reset();
    iom_in = 1'b1; a_in = 16'h0001;
    #3 rst_n = 1'b0;
    in_reset = 1'b1;
    #1;
    chk("reset_valid", {15'd0, tx_valid_out}, 16'h0000);
    chk("reset_status", io_out, 16'h0001);
    chk("reset_data", tx_data_out, 16'h0000);
    run = 1'b1;
    @(posedge clk);
    #1;
    rd(16'h0001, 1'b0);
    rst_n = 1'b1;
    in_reset = 1'b0;

    // Two pushes then drain in order
    phase = 1;
    wr(16'h0000, 16'h1111, 1'b0);
    wr(16'h0000, 16'h2222, 1'b0);
    chk("head_1111", tx_data_out, 16'h1111);
    peek("status_cnt2", 16'h0001, 16'h0020);
    rd(16'h0001, 1'b1);
    chk("head_2222", tx_data_out, 16'h2222);
    rd(16'h0001, 1'b1);
    peek("status_empty", 16'h0001, 16'h0001);

    // Fill, overflow, W1C, push+pop at full
    phase = 2;
    for (int i = 0; i < DEPTH; i++) wr(16'h0000, 16'h3001 + 16'(i), 1'b0);
    wr(16'h0000, 16'h5555, 1'b0);
    peek("status_ovf", 16'h0001, 16'h004A);
    wr(16'h0001, 16'h0008, 1'b0);
    peek("status_ovf_clr", 16'h0001, 16'h0042);
    wr(16'h0000, 16'h6666, 1'b1);
    peek("status_full_pp", 16'h0001, 16'h0042);
    chk("head_after_pp", tx_data_out, 16'h3002);
    for (int i = 0; i < DEPTH + 1; i++) rd(16'h0001, 1'b1);

    // Input synchroniser latency
    phase = 3;
    g_cur = 16'hA5A5;
    rd(16'h0002, 1'b0);
    rd(16'h0002, 1'b0);
    peek("gpin_sync", 16'h0002, 16'hA5A5);
    rd(16'h0002, 1'b0);

`ifdef IO_PORT_TIMER_EN
    // Timer: autoreload, one-shot hold, set-wins W1C
    phase = 4;
    wr(16'h0003, 16'h0003, 1'b0);
    wr(16'h0004, 16'h0000, 1'b0);
    wr(16'h0005, 16'h0003, 1'b0);
    for (int i = 0; i < 10; i++) rd(16'h0004, 1'b0);
    wr(16'h0004, 16'h0000, 1'b0);
    wr(16'h0005, 16'h0001, 1'b0);
    for (int i = 0; i < 6; i++) rd(16'h0004, 1'b0);
    peek("tcnt_hold", 16'h0004, 16'h0003);
    peek("tctrl_en_clr", 16'h0005, 16'h0000);
    wr(16'h0003, 16'h0000, 1'b0);
    wr(16'h0004, 16'h0000, 1'b0);
    wr(16'h0005, 16'h0003, 1'b0);
    wr(16'h0001, 16'h0004, 1'b0);
    wr(16'h0001, 16'h0004, 1'b0);
    peek("texp_set_wins", 16'h0001, 16'h0005);
    wr(16'h0005, 16'h0000, 1'b0);
    wr(16'h0001, 16'h0004, 1'b0);
    peek("texp_cleared", 16'h0001, 16'h0001);
    wr(16'h0003, 16'hFFFF, 1'b0);
`else
    phase = 4;
    wr(16'h0003, 16'h0003, 1'b0);
    wr(16'h0005, 16'h0003, 1'b0);
    peek("notimer_tctrl", 16'h0005, 16'h0000);
`endif

    // Decode: non-I/O cycle and out-of-window address
    phase = 5;
    cycle(16'h0000, 16'h7777, 1'b1, 1'b0, 1'b0, g_cur);
    cycle(16'h0008, 16'h7777, 1'b1, 1'b1, 1'b0, g_cur);
    peek("decode_nochange", 16'h0001, 16'h0001);
    a_in = 16'h0009; #1;
    chk("decode_outside", io_out, 16'h0000);

    // Reset mid-operation with FIFO contents pending
    phase = 6;
    wr(16'h0000, 16'hBEEF, 1'b0);
    wr(16'h0000, 16'hCAFE, 1'b0);
    async_reset();

    // Randomised traffic
    phase = 7;
    pready = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) pready = (c / 200) % 3 == 0 ? 10 : ((c / 200) % 3 == 1 ? 50 : 90);
      if (c % 900 == 899) async_reset();
      rr = $urandom_range(0, 99);
      if (rr < 4)       ra = 16'h0008 | 16'($urandom_range(0, 7));
      else if (rr < 6)  ra = 16'($urandom);
      else if (rr < 36) ra = 16'h0000;
      else              ra = 16'($urandom_range(0, 7));
      case (ra)
        16'h0003, 16'h0004: rdat = 16'($urandom_range(0, 6));
        default:            rdat = 16'($urandom);
      endcase
      if ($urandom_range(0, 99) < 20) g_cur = GW'($urandom);
      cycle(ra, rdat, $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 92,
            $urandom_range(0, 99) < pready, g_cur);
    end

    #20;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
